// File: rtl/omi_lane_channel.sv
// Multi-lane DLx PHY channel model: lane map, delay line, per-lane 66b block aligner with slip tracking.
// Latency DELAY+1 core clocks; no backpressure, tx_* accepted every clock.
// Optional one-shot bit-flip injection when OMI_LANE_CHANNEL_ERR_INJ_EN is defined.
module omi_lane_channel #(
    parameter int LANES        = 8,
    parameter int DATA_W       = 64,
    parameter int DELAY        = 2,
    parameter int INIT_OFFSET  = 0,
    parameter int SLIP_HOLDOFF = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LANES-1:0]         tx_valid,
    input  logic [2*LANES-1:0]       tx_header,
    input  logic [DATA_W*LANES-1:0]  tx_data,
    input  logic [LANES-1:0]         lane_en,
    input  logic                     lane_rev,
    input  logic [LANES-1:0]         rx_slip,
`ifdef OMI_LANE_CHANNEL_ERR_INJ_EN
    input  logic                     inj_stb,
    input  logic [3:0]               inj_lane,
    input  logic [6:0]               inj_bit,
    output logic                     inj_done,
`endif
    output logic [LANES-1:0]         rx_valid,
    output logic [2*LANES-1:0]       rx_header,
    output logic [DATA_W*LANES-1:0]  rx_data,
    output logic [15:0]              slip_cnt,
    output logic [LANES-1:0]         aligned
);
    localparam int B     = DATA_W + 2;
    localparam int OFF_W = $clog2(B);
    localparam int HO_W  = $clog2(SLIP_HOLDOFF + 1);
    localparam logic [OFF_W-1:0] OFF_INIT = OFF_W'(INIT_OFFSET);
    localparam logic [OFF_W-1:0] OFF_MAX  = OFF_W'(B - 1);
    localparam logic [HO_W-1:0]  HO_LOAD  = HO_W'(SLIP_HOLDOFF);

    typedef logic [B-1:0] blk_t;

    blk_t [LANES-1:0] in_blk;
    logic [LANES-1:0] in_vld;
    blk_t [LANES-1:0] d_blk;
    logic [LANES-1:0] d_vld;
    blk_t [LANES-1:0] c_blk;
    blk_t [LANES-1:0] win_blk;
    blk_t [LANES-1:0] flip;
    blk_t [LANES-1:0] rx_blk;
    logic [OFF_W-1:0] off [LANES];
    logic [HO_W-1:0]  holdoff [LANES];
    logic [LANES-1:0] slip_acc;
    logic [16:0]      slip_sum;
    logic [16:0]      cnt_nxt;

    // Lane mapping is resolved before the first register so a lane_rev toggle only affects new blocks.
    always_comb begin
        for (int n = 0; n < LANES; n++) begin
            if (lane_rev) begin
                in_vld[n] = tx_valid[LANES-1-n];
                in_blk[n] = {tx_header[2*(LANES-1-n) +: 2], tx_data[DATA_W*(LANES-1-n) +: DATA_W]};
            end else begin
                in_vld[n] = tx_valid[n];
                in_blk[n] = {tx_header[2*n +: 2], tx_data[DATA_W*n +: DATA_W]};
            end
        end
    end

    generate
        if (DELAY == 0) begin : g_nodly
            assign d_vld = in_vld;
            assign d_blk = in_blk;
        end else begin : g_dly
            logic [LANES-1:0] p_vld [DELAY];
            blk_t [LANES-1:0] p_blk [DELAY];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DELAY; i++) begin
                        p_vld[i] <= '0;
                        p_blk[i] <= '0;
                    end
                end else begin
                    p_vld[0] <= in_vld;
                    p_blk[0] <= in_blk;
                    for (int i = 1; i < DELAY; i++) begin
                        p_vld[i] <= p_vld[i-1];
                        p_blk[i] <= p_blk[i-1];
                    end
                end
            end
            assign d_vld = p_vld[DELAY-1];
            assign d_blk = p_blk[DELAY-1];
        end
    endgenerate

    // Window is {arriving block, previously stored block}; offset 0 selects the arriving block untouched.
    always_comb begin
        for (int n = 0; n < LANES; n++) begin
            win_blk[n]  = blk_t'({d_blk[n], c_blk[n]} >> (B - int'(off[n])));
            slip_acc[n] = rx_slip[n] & lane_en[n] & (holdoff[n] == '0);
            aligned[n]  = (off[n] == '0);
        end
    end

    always_comb begin
        slip_sum = '0;
        for (int n = 0; n < LANES; n++) begin
            slip_sum = slip_sum + 17'(slip_acc[n]);
        end
        cnt_nxt = 17'(slip_cnt) + slip_sum;
    end

`ifdef OMI_LANE_CHANNEL_ERR_INJ_EN
    logic       inj_armed;
    logic [3:0] inj_tl;
    logic [6:0] inj_tb;
    logic       inj_hit;
    logic       inj_ok;

    assign inj_ok = inj_stb && (int'(inj_lane) < LANES) && (int'(inj_bit) < B);

    always_comb begin
        flip    = '0;
        inj_hit = 1'b0;
        for (int n = 0; n < LANES; n++) begin
            if (inj_armed && (inj_tl == 4'(n)) && d_vld[n] && lane_en[n]) begin
                flip[n] = blk_t'(1) << inj_tb;
                inj_hit = 1'b1;
            end
        end
    end

    // A fresh strobe wins over disarming so a re-strobe always leaves the new target armed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inj_armed <= 1'b0;
            inj_tl    <= '0;
            inj_tb    <= '0;
            inj_done  <= 1'b0;
        end else begin
            inj_done <= inj_hit;
            if (inj_ok) begin
                inj_armed <= 1'b1;
                inj_tl    <= inj_lane;
                inj_tb    <= inj_bit;
            end else if (inj_hit) begin
                inj_armed <= 1'b0;
            end
        end
    end
`else
    assign flip = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_blk    <= '0;
            rx_valid <= '0;
            rx_blk   <= '0;
            slip_cnt <= '0;
            for (int n = 0; n < LANES; n++) begin
                off[n]     <= OFF_INIT;
                holdoff[n] <= '0;
            end
        end else begin
            slip_cnt <= cnt_nxt[16] ? 16'hFFFF : cnt_nxt[15:0];
            for (int n = 0; n < LANES; n++) begin
                if (d_vld[n]) begin
                    c_blk[n] <= d_blk[n];
                end
                rx_valid[n] <= d_vld[n] & lane_en[n];
                rx_blk[n]   <= (d_vld[n] & lane_en[n]) ? (win_blk[n] ^ flip[n]) : '0;
                if (slip_acc[n]) begin
                    off[n]     <= (off[n] == OFF_MAX) ? '0 : off[n] + 1'b1;
                    holdoff[n] <= HO_LOAD;
                end else if (holdoff[n] != '0) begin
                    holdoff[n] <= holdoff[n] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int n = 0; n < LANES; n++) begin
            rx_header[2*n +: 2]        = rx_blk[n][B-1 -: 2];
            rx_data[DATA_W*n +: DATA_W] = rx_blk[n][DATA_W-1:0];
        end
    end

endmodule
